// File: rtl/regfile.sv
// 32x32 MIPS register file: two combinational read ports, one write port, post-reset clear sequencer.
// Optional write-through forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              init_done
);

  localparam logic [1:0] RESET = 2'd0;
  localparam logic [1:0] INIT  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] mem [NUM_REGS];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RESET;
      clr_idx   <= ADDR_W'(1);
      init_done <= 1'b0;
    end else begin
      case (state)
        RESET: state <= INIT;
        INIT: begin
          clr_idx <= clr_idx + ADDR_W'(1);
          if (clr_idx == LAST_IDX) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN:     state <= RUN;
        default: state <= RESET;
      endcase
    end
  end

  // Clear sequencer and WB share one write port; reset itself never touches contents.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (rst) begin
      if (state == INIT) begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx;
        mem_wdata = '0;
      end else if (state == RUN && we && waddr != '0) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rdata1 = '0;
    if (rst && state == RUN && re1 && raddr1 != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (we && waddr == raddr1) rdata1 = wdata;
      else                       rdata1 = mem[raddr1];
`else
      rdata1 = mem[raddr1];
`endif
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst && state == RUN && re2 && raddr2 != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (we && waddr == raddr2) rdata2 = wdata;
      else                       rdata2 = mem[raddr2];
`else
      rdata2 = mem[raddr2];
`endif
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        init_done;

  int unsigned checks;
  int unsigned fails;

  regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (init_done !== 1'b0) begin fails++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      fails++; $display("FAIL reset_rdata got=%h/%h exp=0/0", rdata1, rdata2);
    end
    @(negedge clk); rst = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      checks++;
      if (init_done !== (e == 32)) begin
        fails++; $display("FAIL init_done_edge%0d got=%b exp=%b", e, init_done, (e == 32));
      end
      checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        fails++; $display("FAIL init_rdata_edge%0d got=%h/%h exp=0/0", e, rdata1, rdata2);
      end
    end
  endtask

  task automatic test_basic_rw();
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; re1 = 1'b0; re2 = 1'b0;
    @(negedge clk);
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'h12345678) begin fails++; $display("FAIL basic_rd1 got=%h exp=12345678", rdata1); end
    checks++;
    if (rdata2 !== 32'h12345678) begin fails++; $display("FAIL basic_rd2 got=%h exp=12345678", rdata2); end
  endtask

  task automatic test_zero_and_enable();
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin fails++; $display("FAIL r0_during_write got=%h exp=0", rdata1); end
    @(negedge clk);
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin fails++; $display("FAIL r0_read got=%h exp=0", rdata1); end
    checks++;
    if (rdata2 !== 32'h0) begin fails++; $display("FAIL re2_off got=%h exp=0", rdata2); end
    re2 = 1'b1;
    #1;
    checks++;
    if (rdata2 !== 32'h12345678) begin fails++; $display("FAIL re2_on got=%h exp=12345678", rdata2); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'h11111111;
`endif
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h11111111; re1 = 1'b0; re2 = 1'b0;
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; re2 = 1'b1; raddr2 = 5'd7; re1 = 1'b1; raddr1 = 5'd5;
    #1;
    checks++;
    if (rdata2 !== exp_same) begin fails++; $display("FAIL bypass_rd2 got=%h exp=%h", rdata2, exp_same); end
    checks++;
    if (rdata1 !== 32'h12345678) begin fails++; $display("FAIL bypass_other_addr got=%h exp=12345678", rdata1); end
    raddr1 = 5'd7;
    #1;
    checks++;
    if (rdata1 !== exp_same) begin fails++; $display("FAIL bypass_rd1 got=%h exp=%h", rdata1, exp_same); end
    @(negedge clk);
    we = 1'b0;
    #1;
    checks++;
    if (rdata2 !== 32'hA5A5A5A5) begin fails++; $display("FAIL after_write_rd2 got=%h exp=a5a5a5a5", rdata2); end
    checks++;
    if (rdata1 !== 32'hA5A5A5A5) begin fails++; $display("FAIL after_write_rd1 got=%h exp=a5a5a5a5", rdata1); end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd7;
    #1;
    checks++;
    if (rdata1 !== 32'h12345678) begin fails++; $display("FAIL pre_reset_r5 got=%h exp=12345678", rdata1); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin fails++; $display("FAIL midrun_rst_rdata1 got=%h exp=0", rdata1); end
    @(posedge clk); #1;
    checks++;
    if (init_done !== 1'b0) begin fails++; $display("FAIL midrun_init_done got=%b exp=0", init_done); end
    @(negedge clk); rst = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      if (e >= 31) begin
        checks++;
        if (init_done !== (e == 32)) begin
          fails++; $display("FAIL midrun_init_edge%0d got=%b exp=%b", e, init_done, (e == 32));
        end
      end
    end
    checks++;
    if (rdata1 !== 32'h0) begin fails++; $display("FAIL r5_cleared got=%h exp=0", rdata1); end
    checks++;
    if (rdata2 !== 32'h0) begin fails++; $display("FAIL r7_cleared got=%h exp=0", rdata2); end
  endtask

  task automatic test_init_write_block();
    @(negedge clk);
    rst = 1'b0; we = 1'b0; re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd2;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      if (e == 5) begin we = 1'b1; waddr = 5'd9; wdata = 32'hDEADBEEF; end
      if (e == 6) begin we = 1'b1; waddr = 5'd2; wdata = 32'hDEADBEEF; end
      if (e == 7) we = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
    end
    checks++;
    if (init_done !== 1'b1) begin fails++; $display("FAIL block_init_done got=%b exp=1", init_done); end
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin fails++; $display("FAIL blocked_r9 got=%h exp=0", rdata1); end
    checks++;
    if (rdata2 !== 32'h0) begin fails++; $display("FAIL blocked_r2 got=%h exp=0", rdata2); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic_rw();
    test_zero_and_enable();
    test_bypass();
    test_reset_midrun();
    test_init_write_block();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file of the 5-stage MIPS core: 32 x 32-bit registers, two read ports, one write port.
- Acts as the responder to the ID stage's read requests (enable plus address per operand), returning operand data in the same cycle.
- Accepts writeback from the WB stage.
- Contains a post-reset clear sequencer that zeroes every register before signalling ready to the pipeline.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers (2**ADDR_W); register 0 hardwired to zero

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 resets on the rising edge of clk)
- we  in  1  write enable from WB
- waddr  in  ADDR_W  write register address
- wdata  in  DATA_W  write data
- re1  in  1  read enable, port 1 (ID reg1_read)
- raddr1  in  ADDR_W  read address, port 1
- rdata1  out  DATA_W  read data, port 1 (combinational)
- re2  in  1  read enable, port 2 (ID reg2_read)
- raddr2  in  ADDR_W  read address, port 2
- rdata2  out  DATA_W  read data, port 2 (combinational)
- init_done  out  1  registered; 1 once the clear sequence completes, pipeline stalls while 0

Behaviour:
- State machine: states RESET, INIT, RUN; 5-bit clear counter clr_idx.
- rst==0 at a clock edge:
  - state goes to RESET, clr_idx becomes 1, init_done becomes 0.
  - Register contents are not modified by the reset itself.
  - rdata1 and rdata2 are forced to 0 combinationally while rst==0.
- RESET -> INIT on the first edge with rst==1.
- INIT:
  - Each edge writes 0 to mem[clr_idx] and increments clr_idx.
  - Registers 1..31 are cleared over 31 consecutive cycles.
  - The edge that clears index NUM_REGS-1 moves to RUN and sets init_done=1.
  - Total: init_done rises on the 32nd rising edge after rst is released (1 RESET->INIT edge plus 31 clear edges).
- While state != RUN:
  - External writes (we) are ignored.
  - rdata1 and rdata2 read 0.
- RUN write: on a rising edge with we==1 and waddr!=0, mem[waddr] <= wdata. A write to address 0 is discarded.
- RUN read, port n (evaluated in priority order):
  - ren==0 -> rdatan=0
  - else raddrn==0 -> 0
  - else bypass condition (see Optional Feature) -> wdata
  - else mem[raddrn]
- Both read ports are independent. Both may read the same address, and both may bypass simultaneously.
- Register 0 always reads 0, including during bypass (bypass is suppressed when waddr==0).
- Reset mid-operation:
  - rst==0 at any point aborts INIT or RUN.
  - On release the full clear sequence reruns; previously written values are zeroed.
- Reset held for multiple cycles: stays in RESET, clr_idx held at 1.
- No X is ever driven on rdata; unread ports output 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, if ren==1, raddrn!=0, we==1 and waddr==raddrn, rdatan = wdata in the same cycle (write-through forwarding, closing the WB->ID hazard).
- Not defined: no forwarding; rdatan = mem[raddrn] (the old value) until the edge commits the write. The pipeline must resolve that hazard elsewhere.

Test Plan:
- Reset/init: hold rst=0 for 3 cycles, release -> init_done=0 for 31 edges, init_done=1 after the 32nd edge; rdata1=rdata2=0 throughout (re1=re2=1, raddr1=3).
- Basic write/read:
  - Write r5=0x12345678 (we=1, waddr=5).
  - Next cycle, re1=1, raddr1=5 -> rdata1=0x12345678.
  - Same cycle, re2=1, raddr2=5 -> rdata2=0x12345678.
- Zero register and enable:
  - Write r0=0xFFFFFFFF, then re1=1, raddr1=0 -> rdata1=0.
  - re2=0, raddr2=5 (holding 0x12345678) -> rdata2=0.
- Bypass: r7 holds 0x11111111; same cycle we=1, waddr=7, wdata=0xA5A5A5A5, re2=1, raddr2=7 -> rdata2=0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x11111111 without. The next cycle reads 0xA5A5A5A5 in both builds.
- Writes blocked during init: after reset release, write r9=0xDEADBEEF on the 5th edge -> after init_done=1, r9 reads 0.
- Reset mid-run:
  - r5=0x12345678 in RUN; assert rst=0 for 1 cycle -> init_done drops to 0, rdata1=0.
  - After the clear sequence completes, r5 reads 0.
